// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, owner record and
// the data-bus width.
package mem_port_arbiter_pkg;

    localparam int DATA_W      = 64;
    localparam int MAX_NFU     = 16;
    localparam int OWNER_IDX_W = $clog2(MAX_NFU);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } arbState_e;

    // The owner is either the fetch unit or one FU, identified by its index.
    typedef struct packed {
        logic                   isFetch;
        logic [OWNER_IDX_W-1:0] fuIdx;
    } owner_t;

    function automatic int fuIdxWidth(input int nfu);
        return (nfu > 1) ? $clog2(nfu) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int NFU = 8,
    parameter int PAW = 56
);
    logic                         fetchReq;
    logic [PAW-1:0]               fetchAddr;
    logic                         fetchDone;
    logic [NFU-1:0]               fuReq;
    logic [NFU-1:0]               fuWrite;
    logic [NFU-1:0][PAW-1:0]      fuAddr;
    logic [NFU-1:0][DATA_W-1:0]   fuWdata;
    logic [NFU-1:0]               fuDone;
    logic [DATA_W-1:0]            rdata;
    logic                         memReq;
    logic                         memWrite;
    logic [PAW-1:0]               memAddr;
    logic [DATA_W-1:0]            memWdata;
    logic                         memAck;
    logic [DATA_W-1:0]            memRdata;

    // master: requesters plus memory model; slave: the arbiter itself
    modport master (
        output fetchReq, fetchAddr, fuReq, fuWrite, fuAddr, fuWdata, memAck, memRdata,
        input  fetchDone, fuDone, rdata, memReq, memWrite, memAddr, memWdata
    );

    modport slave (
        input  fetchReq, fetchAddr, fuReq, fuWrite, fuAddr, fuWdata, memAck, memRdata,
        output fetchDone, fuDone, rdata, memReq, memWrite, memAddr, memWdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module mem_port_arbiter_rr_picker #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW:0] cand;

    // Scan from the farthest candidate back to ptr so the closest hit is kept last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (req[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch vs. NFU functional units, one access in flight,
// fetch priority with forced alternation and round-robin among FUs.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NFU                   = 8,
    parameter int PHYSICAL_ADDRESS_SIZE = 56
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int IDXW = fuIdxWidth(NFU);
    localparam logic [1:0]      ST_IDLE = IDLE;
    localparam logic [1:0]      ST_BUS  = BUS;
    localparam logic [1:0]      ST_DONE = DONE;
    localparam logic [IDXW-1:0] LAST_FU = IDXW'(NFU - 1);

    logic [1:0]                       state;
    logic [IDXW-1:0]                  rrPtr;
    logic                             prevFetch;
    owner_t                           owner;
    logic [PHYSICAL_ADDRESS_SIZE-1:0] addrReg;
    logic                             writeReg;
    logic [DATA_W-1:0]                wdataReg;
    logic [DATA_W-1:0]                rdataReg;

    logic            pickValid;
    logic [IDXW-1:0] pickIdx;
    logic            fetchWins;

    mem_port_arbiter_rr_picker #(.N(NFU), .IW(IDXW)) rrPicker (
        .req   (bus.fuReq),
        .ptr   (rrPtr),
        .valid (pickValid),
        .idx   (pickIdx)
    );

    // A fetch that just owned the bus yields to any waiting FU.
    assign fetchWins = bus.fetchReq && !(prevFetch && (|bus.fuReq));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rrPtr     <= '0;
            prevFetch <= 1'b0;
            owner     <= '0;
            addrReg   <= '0;
            writeReg  <= 1'b0;
            wdataReg  <= '0;
            rdataReg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetchWins) begin
                        state         <= ST_BUS;
                        prevFetch     <= 1'b1;
                        owner.isFetch <= 1'b1;
                        owner.fuIdx   <= '0;
                        addrReg       <= bus.fetchAddr;
                        writeReg      <= 1'b0;
                        wdataReg      <= '0;
                    end else if (pickValid) begin
                        state         <= ST_BUS;
                        prevFetch     <= 1'b0;
                        owner.isFetch <= 1'b0;
                        owner.fuIdx   <= OWNER_IDX_W'(pickIdx);
                        addrReg       <= bus.fuAddr[pickIdx];
                        writeReg      <= bus.fuWrite[pickIdx];
                        wdataReg      <= bus.fuWdata[pickIdx];
                        rrPtr         <= (pickIdx == LAST_FU) ? '0 : pickIdx + 1'b1;
                    end
                end
                ST_BUS: begin
                    if (bus.memAck) begin
                        if (!writeReg) begin
                            rdataReg <= bus.memRdata;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.memReq    = (state == ST_BUS);
    assign bus.memWrite  = (state == ST_BUS) && writeReg;
    assign bus.memAddr   = addrReg;
    assign bus.memWdata  = wdataReg;
    assign bus.rdata     = rdataReg;
    assign bus.fetchDone = (state == ST_DONE) && owner.isFetch;
    assign bus.fuDone    = ((state == ST_DONE) && !owner.isFetch) ? (NFU'(1) << owner.fuIdx) : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NFU = 8;
    localparam int PAW = 56;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NFU(NFU), .PAW(PAW)) bus ();

    mem_port_arbiter #(.NFU(NFU), .PHYSICAL_ADDRESS_SIZE(PAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: phase 0 idle, 1 on bus, 2 completing; owner -1 = fetch, -2 = none
    int          mSt;
    int          mOwn;
    int          mPtr;
    bit          mPrevFetch;
    bit          mWr;
    logic [63:0] mRdata;
    logic [63:0] mAddr;
    logic [63:0] mWdata;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ohIdx(input logic [NFU-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NFU; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int pickWinner();
        if (bus.fetchReq && !(mPrevFetch && (bus.fuReq != '0))) return -1;
        for (int k = 0; k < NFU; k++) begin
            if (bus.fuReq[(mPtr + k) % NFU]) return (mPtr + k) % NFU;
        end
        return -2;
    endfunction

    task automatic modelAdvance();
        int w;
        if (rst) begin
            mSt = 0; mPtr = 0; mPrevFetch = 0; mRdata = '0; mOwn = -2;
            return;
        end
        case (mSt)
            0: begin
                w = pickWinner();
                if (w != -2) begin
                    mSt = 1; mOwn = w; mPrevFetch = (w == -1);
                    if (w == -1) begin
                        mAddr = 64'(bus.fetchAddr); mWr = 0;
                    end else begin
                        mAddr  = 64'(bus.fuAddr[w]);
                        mWr    = bus.fuWrite[w];
                        mWdata = bus.fuWdata[w];
                        mPtr   = (w + 1) % NFU;
                    end
                end
            end
            1: if (bus.memAck) begin
                if (!mWr) mRdata = bus.memRdata;
                mSt = 2;
            end
            default: mSt = 0;
        endcase
    endtask

    task automatic checkOutputs();
        checkVal("memReq", 64'(bus.memReq), 64'(mSt == 1));
        checkVal("memWrite", 64'(bus.memWrite), 64'(mSt == 1 && mWr));
        if (mSt == 1) begin
            checkVal("memAddr", 64'(bus.memAddr), mAddr);
            if (mWr) checkVal("memWdata", bus.memWdata, mWdata);
        end
        checkVal("fetchDone", 64'(bus.fetchDone), 64'(mSt == 2 && mOwn == -1));
        checkVal("fuDone", 64'(bus.fuDone), (mSt == 2 && mOwn >= 0) ? (64'd1 << mOwn) : 64'd0);
        checkVal("rdata", bus.rdata, mRdata);
    endtask

    // Inputs are set by the caller before step; the model predicts the next edge.
    task automatic step();
        modelAdvance();
        @(negedge clk);
        checkOutputs();
    endtask

    task automatic releaseDone();
        if (mSt == 2) begin
            if (mOwn == -1) bus.fetchReq = 1'b0;
            else if (mOwn >= 0) bus.fuReq[mOwn] = 1'b0;
        end
    endtask

    task automatic clearInputs();
        bus.fetchReq  = 1'b0;
        bus.fetchAddr = '0;
        bus.fuReq     = '0;
        bus.fuWrite   = '0;
        bus.fuAddr    = '0;
        bus.fuWdata   = '0;
        bus.memAck    = 1'b0;
        bus.memRdata  = '0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkVal("rst_memAddr", 64'(bus.memAddr), 64'd0);
        checkVal("rst_memWdata", bus.memWdata, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int k;
        int rearm;
        int obs;
        int justRel;
        int exp35 [4] = '{-1, 5, -1, 5};
        logic [63:0] a36;
        logic [63:0] d36;

        clearInputs();
        @(negedge clk);

        // Single FU3 load
        doReset();
        bus.fuReq[3] = 1'b1; bus.fuWrite[3] = 1'b0; bus.fuAddr[3] = PAW'(64'h1000);
        bus.memRdata = 64'hDEAD;
        step();
        checkVal("t33_memReq", 64'(bus.memReq), 64'd1);
        checkVal("t33_addr", 64'(bus.memAddr), 64'h1000);
        bus.memAck = 1'b1;
        step();
        checkVal("t33_done", 64'(bus.fuDone), 64'h8);
        checkVal("t33_rdata", bus.rdata, 64'hDEAD);
        checkVal("t33_memReqDrop", 64'(bus.memReq), 64'd0);
        releaseDone();
        bus.memAck = 1'b0;
        step();
        checkVal("t33_idle", 64'(bus.fuDone), 64'd0);

        // All FUs requesting: strict rotation 0..7 then 0
        doReset();
        bus.memAck = 1'b1; bus.fuReq = '1; k = 0; rearm = -1;
        for (int c = 0; c < 80 && k < 9; c++) begin
            step();
            if (rearm >= 0) begin bus.fuReq[rearm] = 1'b1; rearm = -1; end
            if (bus.fuDone != '0) begin
                checkVal("t34_order", 64'(ohIdx(bus.fuDone)), 64'(k % NFU));
                k++;
            end
            if (mSt == 2 && mOwn >= 0) rearm = mOwn;
            releaseDone();
        end
        checkVal("t34_count", 64'(k), 64'd9);

        // Fetch and FU5 both held: owners alternate
        doReset();
        bus.memAck = 1'b1; bus.fetchReq = 1'b1; bus.fuReq[5] = 1'b1; k = 0; rearm = -2;
        for (int c = 0; c < 60 && k < 4; c++) begin
            step();
            if (rearm == -1) bus.fetchReq = 1'b1;
            else if (rearm >= 0) bus.fuReq[rearm] = 1'b1;
            rearm = -2;
            if (bus.fetchDone || bus.fuDone != '0) begin
                obs = bus.fetchDone ? -1 : ohIdx(bus.fuDone);
                checkVal("t35_owner", 64'(obs), 64'(exp35[k]));
                k++;
            end
            if (mSt == 2) rearm = mOwn;
            releaseDone();
        end
        checkVal("t35_count", 64'(k), 64'd4);

        // FU2 store with a slow memory
        doReset();
        a36 = 64'(PAW'({$urandom(), $urandom()}));
        d36 = {$urandom(), $urandom()};
        bus.fuReq[2] = 1'b1; bus.fuWrite[2] = 1'b1;
        bus.fuAddr[2] = PAW'(a36); bus.fuWdata[2] = d36;
        bus.memRdata = {$urandom(), $urandom()};
        for (int c = 0; c < 10; c++) begin
            step();
            checkVal("t36_memReq", 64'(bus.memReq), 64'd1);
            checkVal("t36_memWrite", 64'(bus.memWrite), 64'd1);
            checkVal("t36_addr", 64'(bus.memAddr), a36);
            checkVal("t36_wdata", bus.memWdata, d36);
            checkVal("t36_rdata", bus.rdata, 64'd0);
            if (c == 9) bus.memAck = 1'b1;
        end
        step();
        checkVal("t36_done", 64'(bus.fuDone), 64'h4);
        checkVal("t36_rdataHold", bus.rdata, 64'd0);
        releaseDone();
        bus.memAck = 1'b0;
        step();
        checkVal("t36_idle", 64'(bus.fuDone), 64'd0);

        // Reset in the middle of an access
        doReset();
        bus.fuReq[1] = 1'b1; bus.fuAddr[1] = PAW'(64'h2468); bus.memRdata = 64'h1234;
        step();
        checkVal("t37_busy", 64'(bus.memReq), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkVal("t37_abortReq", 64'(bus.memReq), 64'd0);
        checkVal("t37_abortDone", 64'(bus.fuDone), 64'd0);
        step();
        checkVal("t37_regrant", 64'(bus.memReq), 64'd1);
        bus.memAck = 1'b1;
        step();
        checkVal("t37_done", 64'(bus.fuDone), 64'h2);
        checkVal("t37_rdata", bus.rdata, 64'h1234);
        releaseDone();

        // Spurious acknowledge with nothing pending
        doReset();
        bus.memAck = 1'b1; bus.memRdata = 64'hBAD0BAD0;
        for (int c = 0; c < 5; c++) begin
            step();
            checkVal("t38_memReq", 64'(bus.memReq), 64'd0);
            checkVal("t38_done", 64'({bus.fetchDone, bus.fuDone}), 64'd0);
            checkVal("t38_rdata", bus.rdata, 64'd0);
        end

        // Randomized traffic with withdrawals, variable ack delay and sporadic reset
        doReset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            bus.memAck = ($urandom_range(0, 2) == 0);
            bus.memRdata = {$urandom(), $urandom()};
            step();
            justRel = (mSt == 2) ? mOwn : -2;
            releaseDone();
            if (bus.fetchReq) begin
                if (!(mSt != 0 && mOwn == -1) && $urandom_range(0, 15) == 0) bus.fetchReq = 1'b0;
            end else if (justRel != -1 && $urandom_range(0, 3) == 0) begin
                bus.fetchReq  = 1'b1;
                bus.fetchAddr = PAW'({$urandom(), $urandom()});
            end
            for (int i = 0; i < NFU; i++) begin
                if (bus.fuReq[i]) begin
                    if (!(mSt != 0 && mOwn == i) && $urandom_range(0, 15) == 0) bus.fuReq[i] = 1'b0;
                end else if (justRel != i && $urandom_range(0, 5) == 0) begin
                    bus.fuReq[i]   = 1'b1;
                    bus.fuWrite[i] = $urandom_range(0, 1) == 1;
                    bus.fuAddr[i]  = PAW'({$urandom(), $urandom()});
                    bus.fuWdata[i] = {$urandom(), $urandom()};
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NFU, default 8, number of functional-unit memory requesters (1..16).
REQ-002 Parameter PHYSICAL_ADDRESS_SIZE, default 56, memory address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fetchReq  input  1  instruction-fetch requester wants the bus; held until fetchDone.
REQ-006 fetchAddr  input  PHYSICAL_ADDRESS_SIZE  fetch read address; stable while fetchReq is high.
REQ-007 fetchDone  output  1  one-cycle pulse; rdata is valid for fetch this cycle.
REQ-008 fuReq  input  NFU  per-FU request; held until the matching fuDone bit.
REQ-009 fuWrite  input  NFU  per-FU store (1) / load (0) select.
REQ-010 fuAddr  input  NFU x PHYSICAL_ADDRESS_SIZE  per-FU address.
REQ-011 fuWdata  input  NFU x 64  per-FU store data.
REQ-012 fuDone  output  NFU  one-hot one-cycle completion pulse.
REQ-013 rdata  output  64  registered load/fetch data, valid only with a done pulse.
REQ-014 memReq, memWrite  output  1 each  bus request and direction.
REQ-015 memAddr  output  PHYSICAL_ADDRESS_SIZE; memWdata  output  64.
REQ-016 memAck  input  1; memRdata  input  64  memory completes access in any cycle memAck is high.

Function
REQ-017 FSM states IDLE, BUS, DONE; IDLE -> BUS when any request is present; BUS -> DONE on memAck; DONE -> IDLE unconditionally.
REQ-018 Arbitration is evaluated only in IDLE; the winner is latched into an owner register together with its address, write flag and data.
REQ-019 Fetch wins over FUs, except that when the previous owner was fetch and any fuReq bit is set, an FU wins (anti-starvation alternation).
REQ-020 Among FUs: round-robin starting from pointer rrPtr, searching upward with wrap from NFU-1 to 0.
REQ-021 On an FU grant rrPtr becomes (winner+1) mod NFU; rrPtr is unchanged on a fetch grant.
REQ-022 In BUS: memReq=1 and memAddr/memWrite/memWdata driven from the latched registers, all stable until memAck.
REQ-023 memAck sampled high in BUS: memRdata is captured into rdata (loads and fetch only; rdata holds for stores); memReq drops next cycle.
REQ-024 In DONE, exactly one of fetchDone / fuDone[owner] is 1 for one cycle; the requester drops its request in that cycle.
REQ-025 Minimum latency: request in IDLE cycle N -> memReq in N+1 -> memAck at N+1 -> done at N+2; next grant no earlier than N+3.
REQ-026 Requests asserted in BUS/DONE wait; requests withdrawn before grant are ignored, never granted.
REQ-027 memAck outside BUS is ignored.
REQ-028 memReq, memWrite and all done outputs are 0 outside their states.

Reset
REQ-029 On rst: state IDLE, rrPtr 0, previous-owner flag = not fetch, memReq 0, memWrite 0, memAddr 0, memWdata 0, rdata 0, fetchDone 0, fuDone 0.
REQ-030 rst in BUS or DONE aborts immediately; no done pulse is issued for the aborted access.

Structure
REQ-031 Shared package holds the FSM state enum (IDLE/BUS/DONE) and the owner encoding (fetch flag + FU index width $clog2(NFU)).
REQ-032 One sub-module rr_picker: combinational round-robin selector (req vector, pointer) -> (valid, index).

Verification
REQ-033 Single FU3 load, addr 0x1000, memAck one cycle after memReq, memRdata 0xDEAD -> fuDone[3] pulse, rdata 0xDEAD, memReq high exactly 1 cycle.
REQ-034 fuReq=8'hFF held, fetch idle, rrPtr 0 -> grant order 0,1,...,7,0 with one fuDone each.
REQ-035 fetchReq and fuReq[5] both held continuously -> owners alternate fetch,5,fetch,5.
REQ-036 FU2 store, memAck delayed 10 cycles -> memAddr/memWdata stable for all 10 cycles, rdata unchanged, fuDone[2] one cycle after ack.
REQ-037 rst asserted in BUS -> next cycle memReq 0, state IDLE, no done pulse; a subsequent request completes normally.
REQ-038 Spurious memAck in IDLE with no requests -> no done, no state change.
